// File: rtl/riscv_dmem_bridge.sv
// Data-side bridge: routes core loads/stores to a word SRAM (1-cycle read latency)
// or to an MMIO block holding a 64-bit cycle counter, a GPIO register and a byte TX FIFO.
module riscv_dmem_bridge #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  input  logic                         cpu_mem_write,
  input  logic                         cpu_mem_read,
  output logic [31:0]                  cpu_rdata,
  output logic                         cpu_stall,
  output logic [$clog2(RAM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  output logic                         sram_we,
  output logic                         sram_re,
  input  logic [31:0]                  sram_rdata,
  output logic [31:0]                  gpio_out,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_ready,
  output logic                         bus_err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [2:0] REG_CNT_LO = 3'd0;
  localparam logic [2:0] REG_CNT_HI = 3'd1;
  localparam logic [2:0] REG_GPIO   = 3'd2;
  localparam logic [2:0] REG_TX     = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] counter;
  logic [31:0] snapshot;

  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr, rd_ptr;
  logic [3:0]  fifo_count;
  logic        fifo_full, fifo_empty;
  logic        tx_push, tx_pop;

  logic        ram_hit, mmio_hit, rd_req, conflict;
  logic [2:0]  reg_sel;
  logic [31:0] status;
  logic        gpio_we, snap_we, err_set;

  assign sram_addr  = cpu_addr[AW+1:2];
  assign sram_wdata = cpu_wdata;

  assign fifo_full  = (fifo_count == 4'd8);
  assign fifo_empty = (fifo_count == 4'd0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : '0;
  assign tx_pop     = tx_valid && tx_ready;
  assign status     = {25'd0, fifo_count, 1'b0, fifo_empty, fifo_full};

  always_comb begin
    ram_hit  = (cpu_addr < RAM_BYTES);
    mmio_hit = (cpu_addr[31:5] == MMIO_BASE[31:5]) && (cpu_addr[4:2] <= REG_STATUS);
    reg_sel  = cpu_addr[4:2];
    rd_req   = cpu_mem_read && !cpu_mem_write;
    conflict = cpu_mem_read && cpu_mem_write;
  end

  // Request outputs are forced to their reset values while reset is held so a
  // load caught in RD_WAIT cannot complete on the reset cycle.
  always_comb begin
    state_nxt = state;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    tx_push   = 1'b0;
    gpio_we   = 1'b0;
    snap_we   = 1'b0;
    err_set   = 1'b0;
    if (!reset) begin
      if (state == RD_WAIT) begin
        cpu_rdata = sram_rdata;
        state_nxt = IDLE;
      end else if (rd_req) begin
        if (ram_hit) begin
          sram_re   = 1'b1;
          cpu_stall = 1'b1;
          state_nxt = RD_WAIT;
        end else if (mmio_hit) begin
          case (reg_sel)
            REG_CNT_LO: begin
              cpu_rdata = counter[31:0];
              snap_we   = 1'b1;
            end
            REG_CNT_HI: cpu_rdata = snapshot;
            REG_GPIO:   cpu_rdata = gpio_out;
            REG_STATUS: cpu_rdata = status;
            default:    cpu_rdata = '0;
          endcase
        end else begin
          err_set = 1'b1;
        end
      end else if (cpu_mem_write) begin
        if (ram_hit) begin
          sram_we = 1'b1;
        end else if (mmio_hit) begin
          if (reg_sel == REG_GPIO) begin
            gpio_we = 1'b1;
          end else if (reg_sel == REG_TX) begin
            if (fifo_full) cpu_stall = 1'b1;
            else           tx_push   = 1'b1;
          end
        end else begin
          err_set = 1'b1;
        end
        // A read+write collision is flagged once, on the cycle the write lands.
        if (conflict && !cpu_stall) err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      snapshot   <= '0;
      gpio_out   <= '0;
      bus_err    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter + 64'd1;
      if (snap_we) snapshot <= counter[63:32];
      if (gpio_we) gpio_out <= cpu_wdata;
      if (err_set) bus_err  <= 1'b1;
      if (tx_push) wr_ptr   <= wr_ptr + 3'd1;
      if (tx_pop)  rd_ptr   <= rd_ptr + 3'd1;
      fifo_count <= fifo_count + {3'd0, tx_push} - {3'd0, tx_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= cpu_wdata[7:0];
  end

endmodule

// File: tb/tb_riscv_dmem_bridge.sv
// Scoreboard bench for riscv_dmem_bridge: a driver predicts each load result into a
// queue, a negedge monitor pops and compares completions, GPIO, bus_err and TX bytes.
`timescale 1ns/1ps
module tb_riscv_dmem_bridge;

  localparam int unsigned RAM_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam int unsigned AW        = $clog2(RAM_WORDS);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_mem_write, cpu_mem_read, cpu_stall;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          sram_we, sram_re;
  logic [31:0]   gpio_out;
  logic          tx_valid, tx_ready, bus_err;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  riscv_dmem_bridge #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_read(cpu_mem_read),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata),
    .gpio_out(gpio_out), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .bus_err(bus_err)
  );

  // External synchronous SRAM; the bench only ever reads words it has written.
  logic [31:0] sram_mem [RAM_WORDS];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= sram_mem[sram_addr];
  end

  // Reference state
  logic [63:0] tb_cyc;
  logic [31:0] ref_ram [RAM_WORDS];
  logic [31:0] ref_gpio, ref_snap;
  logic        ref_bus_err;
  logic [7:0]  ref_q [$];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          tx_mode = 0;

  always @(posedge clk) tb_cyc <= reset ? 64'd0 : tb_cyc + 64'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_mode == 2) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: completions, idle rdata, architectural outputs, TX handshakes.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_mem_read && !cpu_stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rdata_unexpected: got 0x%0h with no load outstanding", cpu_rdata);
        end else begin
          chk("rdata", cpu_rdata, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle", cpu_rdata, 0);
      end
      chk("gpio_out", gpio_out, ref_gpio);
      chk("bus_err", bus_err, ref_bus_err);
      chk("tx_valid", tx_valid, ref_q.size() != 0);
      if (tx_valid && tx_ready && ref_q.size() != 0) chk("tx_data", tx_data, ref_q.pop_front());
    end
  end

  // One core access, held until the bridge stops stalling; called at posedge+1.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    bit          is_ram, is_mmio, ram_rd, tx_push, done, exp_stall;
    int unsigned word, off, sz;
    logic [31:0] exp_rd, snap_val;
    is_ram   = addr < 4 * RAM_WORDS;
    is_mmio  = (addr >= MMIO_BASE) && ((addr - MMIO_BASE) < 32'h14);
    word     = addr / 4;
    off      = (addr - MMIO_BASE) & ~32'd3;
    exp_rd   = 0;
    snap_val = tb_cyc[63:32];
    if (rd && !wr) begin
      if (is_ram) exp_rd = ref_ram[word];
      else if (is_mmio) begin
        sz = ref_q.size();
        case (off)
          0:  exp_rd = tb_cyc[31:0];
          4:  exp_rd = ref_snap;
          8:  exp_rd = ref_gpio;
          16: exp_rd = (sz * 8) + ((sz == 0) ? 2 : 0) + ((sz == 8) ? 1 : 0);
          default: exp_rd = 0;
        endcase
      end
    end
    if (rd) exp_q.push_back(exp_rd);
    ram_rd  = rd && !wr && is_ram;
    tx_push = wr && is_mmio && off == 12;
    cpu_addr = addr; cpu_wdata = wd; cpu_mem_read = rd; cpu_mem_write = wr;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      exp_stall = ram_rd ? (c == 0) : (tx_push && ref_q.size() == 8);
      @(negedge clk);
      chk("cpu_stall", cpu_stall, exp_stall);
      chk("sram_re", sram_re, ram_rd && c == 0);
      chk("sram_we", sram_we, wr && is_ram && c == 0);
      if ((wr && is_ram) || (ram_rd && c == 0)) chk("sram_addr", sram_addr, word[AW-1:0]);
      done = !cpu_stall;
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_timeout: addr 0x%0h still stalled after 40 cycles", addr);
    end
    if (rd && !wr && is_mmio && off == 0) ref_snap = snap_val;
    if (wr) begin
      if (is_ram) ref_ram[word] = wd;
      else if (is_mmio && off == 8) ref_gpio = wd;
      else if (tx_push) ref_q.push_back(wd[7:0]);
    end
    if ((!is_ram && !is_mmio) || (rd && wr)) ref_bus_err = 1'b1;
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
  endtask

  task automatic model_reset();
    ref_gpio = '0; ref_snap = '0; ref_bus_err = 1'b0; ref_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, w;
    logic [31:0] a;
    reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    tx_ready = 1'b0;
    model_reset();
    idle(3);
    @(negedge clk);
    chk("rst_rdata", cpu_rdata, 0);   chk("rst_stall", cpu_stall, 0);
    chk("rst_sram_we", sram_we, 0);   chk("rst_sram_re", sram_re, 0);
    chk("rst_gpio", gpio_out, 0);     chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);   chk("rst_bus_err", bus_err, 0);
    tick();
    reset = 1'b0;

    // RAM store then load
    access(0, 1, 32'h10, 32'hDEAD_BEEF);
    access(1, 0, 32'h10, 0);
    // GPIO
    access(0, 1, MMIO_BASE + 32'h08, 32'h0000_00A5);
    access(1, 0, MMIO_BASE + 32'h08, 0);
    // Counter and snapshot; counter-register writes are ignored
    idle(100);
    access(1, 0, MMIO_BASE, 0);
    access(1, 0, MMIO_BASE + 32'h04, 0);
    access(0, 1, MMIO_BASE + 32'h04, 32'hFFFF_FFFF);
    access(1, 0, MMIO_BASE + 32'h04, 0);
    access(1, 0, MMIO_BASE, 0);

    // TX FIFO fill, full-stall, drain
    for (int i = 1; i <= 8; i++) access(0, 1, MMIO_BASE + 32'h0C, 32'(i));
    access(1, 0, MMIO_BASE + 32'h10, 0);
    access(1, 0, MMIO_BASE + 32'h0C, 0);
    fork
      access(0, 1, MMIO_BASE + 32'h0C, 32'h09);
      begin
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
      end
    join
    tx_mode = 1; tx_ready = 1'b1;
    for (int i = 0; i < 20 && ref_q.size() != 0; i++) tick();
    chk("tx_drained", ref_q.size(), 0);
    access(1, 0, MMIO_BASE + 32'h10, 0);

    // Boundaries, unmapped, read+write collision
    access(0, 1, 4 * RAM_WORDS - 4, 32'h1357_9BDF);
    access(1, 0, 4 * RAM_WORDS - 1, 0);
    access(1, 0, 4 * RAM_WORDS, 0);
    access(1, 0, 32'h4000_0000, 0);
    idle(2);
    access(0, 1, MMIO_BASE + 32'h14, 32'h55);
    access(1, 1, 32'h20, 32'h0000_1234);
    access(1, 0, 32'h20, 0);

    // Reset while the RAM load sits in RD_WAIT
    cpu_addr = 32'h10; cpu_mem_read = 1'b1;
    @(negedge clk);
    chk("rdwait_stall", cpu_stall, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rdwait_rst_stall", cpu_stall, 0);
    chk("rdwait_rst_rdata", cpu_rdata, 0);
    tick();
    reset = 1'b0; cpu_mem_read = 1'b0;
    model_reset();
    idle(2);
    access(1, 0, 32'h10, 0);

    // Randomized traffic
    tx_mode = 2;
    for (int i = 0; i < 16; i++) access(0, 1, 32'(i * 4), $urandom);
    access(0, 1, 4 * RAM_WORDS - 4, $urandom);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 16);
      if (w == 16) w = RAM_WORDS - 1;
      case (k)
        0, 1: access(1, 0, w * 4 + $urandom_range(0, 3), 0);
        2, 3: access(0, 1, w * 4, $urandom);
        4:    access(1, 0, MMIO_BASE + $urandom_range(0, 4) * 4 + $urandom_range(0, 3), 0);
        5:    access(0, 1, MMIO_BASE + 32'h08, $urandom);
        6, 7: access(0, 1, MMIO_BASE + 32'h0C, $urandom);
        8: begin
          case ($urandom_range(0, 3))
            0: a = 32'h4000_0000;
            1: a = 4 * RAM_WORDS + $urandom_range(0, 255) * 4;
            2: a = MMIO_BASE + 32'h14 + $urandom_range(0, 2) * 4;
            default: a = 32'h1000_0000 | $urandom;
          endcase
          access($urandom_range(0, 1) == 1, 0, a, 0);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) access(0, 1, MMIO_BASE + (($urandom_range(0, 2) == 2) ? 32'h10 : $urandom_range(0, 1) * 4), $urandom);
          else access(1, 1, w * 4, $urandom);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    tx_mode = 1; tx_ready = 1'b1;
    for (int i = 0; i < 20 && ref_q.size() != 0; i++) tick();
    chk("tx_final_drain", ref_q.size(), 0);
    idle(3);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
